// File: rtl/md_iter_unit_if.sv
// Request/response bus of the iterative multiply/divide unit.
// master = requester/consumer, slave = md_iter_unit.
interface md_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, funct3, src_a, src_b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, src_a, src_b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/md_iter_unit.sv
// Iterative RV-M multiply/divide unit: one radix-2 step per clock on operand
// magnitudes (shift-add multiply, restoring divide), sign fix-up applied on
// the final step. Divide-by-zero and signed overflow bypass the iteration.
module md_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  md_iter_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op;
  logic             r_a_neg, r_b_neg;
  logic [WIDTH-1:0] r_hi, r_lo, r_b, r_result;
  logic [CW-1:0]    r_cnt;

  // ---- request decode (only meaningful on the accept edge) ----
  logic             w_accept, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic             w_b_zero, w_ovf, w_special;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_spec_res;

  assign w_accept = (r_state == IDLE) && bus.in_valid && !flush;
  // signed rs1: MUL MULH MULHSU DIV REM; signed rs2: MUL MULH DIV REM
  assign w_a_sgn  = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3 != 3'b011);
  assign w_b_sgn  = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign w_a_neg  = w_a_sgn & bus.src_a[WIDTH-1];
  assign w_b_neg  = w_b_sgn & bus.src_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -bus.src_a : bus.src_a;
  assign w_b_mag  = w_b_neg ? -bus.src_b : bus.src_b;
  assign w_b_zero = (bus.src_b == '0);
  assign w_ovf    = (bus.funct3 == 3'b100 || bus.funct3 == 3'b110) &&
                    (bus.src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.src_b == '1);
  assign w_special = bus.funct3[2] & (w_b_zero | w_ovf);
  // funct3[1] selects remainder flavour among divide ops
  assign w_spec_res = w_b_zero ? (bus.funct3[1] ? bus.src_a : '1)
                               : (bus.funct3[1] ? '0 : bus.src_a);

  // ---- one iteration step ----
  logic [WIDTH:0]     w_sum, w_shl;
  logic [WIDTH-1:0]   w_diff, w_hi_nxt, w_lo_nxt;
  logic               w_ge, w_last;

  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shl  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge   = (w_shl >= {1'b0, r_b});
  // only consumed when w_ge, so the true difference is < r_b and fits
  assign w_diff = w_shl[WIDTH-1:0] - r_b;
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // multiply: {hi,lo} shifts right with carry; divide: partial remainder in hi, quotient bits into lo
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (!r_op[2]) begin
      {w_hi_nxt, w_lo_nxt} = {w_sum, r_lo[WIDTH-1:1]};
    end else if (w_ge) begin
      w_hi_nxt = w_diff;
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_nxt = w_shl[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  // ---- sign fix-up and result select on the final step ----
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem, w_final;

  assign w_prod   = {w_hi_nxt, w_lo_nxt};
  assign w_prod_s = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
  assign w_quo    = (r_a_neg ^ r_b_neg) ? -w_lo_nxt : w_lo_nxt;
  assign w_rem    = r_a_neg ? -w_hi_nxt : w_hi_nxt;

  // pick the result field for the latched op
  always_comb begin
    w_final = w_rem;
    case (r_op)
      3'b000:                 w_final = w_prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  // ---- FSM ----
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state; flush overrides acceptance and handoff
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (w_last)       w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // operand latch, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= bus.funct3;
      r_a_neg <= w_a_neg;
      r_b_neg <= w_b_neg;
      r_hi    <= '0;
      r_cnt   <= '0;
      // multiply iterates over multiplier bits in lo; divide shifts dividend out of lo
      r_lo    <= bus.funct3[2] ? w_a_mag : w_b_mag;
      r_b     <= bus.funct3[2] ? w_b_mag : w_a_mag;
      if (w_special) r_result <= w_spec_res;
    end else if (r_state == CALC && !flush) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_result <= w_final;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
endmodule
